// File: rtl/axis_frame_fifo_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : axis_frame_fifo_pkg
// Purpose  : Shared types and constants for the AXI-Stream frame FIFO.
// Revision : 1.0
// ---------------------------------------------------------------------------
package axis_frame_fifo_pkg;

  typedef enum logic [0:0] {
    NORMAL = 1'b0,
    DROP   = 1'b1
  } write_state_e;

  localparam int c_min_depth = 4;

  function automatic bit is_pow2(input int value);
    return (value > 0) && ((value & (value - 1)) == 0);
  endfunction

endpackage

`default_nettype wire

// File: rtl/axis_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : AXIS_IF
// Purpose  : AXI-Stream bundle with master/slave views.
// Revision : 1.0
// ---------------------------------------------------------------------------
interface AXIS_IF #(
  parameter int TDATA_WIDTH    = 8,
  parameter int TID_WIDTH      = 1,
  parameter int TDEST_WIDTH    = 1,
  parameter int TUSER_WIDTH    = 1,
  parameter int TWAKEUP_ENABLE = 0
);

  localparam int c_keep_w = (TDATA_WIDTH + 7) / 8;

  logic                   tvalid;
  logic                   tready;
  logic [TDATA_WIDTH-1:0] tdata;
  logic [c_keep_w-1:0]    tkeep;
  logic [c_keep_w-1:0]    tstrb;
  logic                   tlast;
  logic [TID_WIDTH-1:0]   tid;
  logic [TDEST_WIDTH-1:0] tdest;
  logic [TUSER_WIDTH-1:0] tuser;
  logic                   twakeup;

  modport Master (
    output tvalid, tdata, tkeep, tstrb, tlast, tid, tdest, tuser, twakeup,
    input  tready
  );

  modport Slave (
    input  tvalid, tdata, tkeep, tstrb, tlast, tid, tdest, tuser, twakeup,
    output tready
  );

endinterface

`default_nettype wire

// File: rtl/axis_fifo_ram.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : axis_fifo_ram
// Purpose  : Simple dual-port RAM, one write port and one registered read port.
// Revision : 1.0
// ---------------------------------------------------------------------------
module axis_fifo_ram #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     i_wr_en,
  input  logic [$clog2(DEPTH)-1:0] i_wr_addr,
  input  logic [WIDTH-1:0]         i_wr_data,
  input  logic                     i_rd_en,
  input  logic [$clog2(DEPTH)-1:0] i_rd_addr,
  output logic [WIDTH-1:0]         o_rd_data
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rd_data;

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  // Read register only advances on a read, so it doubles as a stall-safe output stage.
  always_ff @(posedge clk) begin
    if (i_rd_en) begin
      r_rd_data <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

`default_nettype wire

// File: rtl/axis_frame_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : axis_frame_fifo
// Purpose  : Store-and-forward AXI-Stream frame FIFO; drops bad and oversize frames.
// Revision : 1.0
// ---------------------------------------------------------------------------
module axis_frame_fifo
  import axis_frame_fifo_pkg::*;
#(
  parameter int DEPTH          = 1024,
  parameter bit DROP_BAD_FRAME = 1'b1,
  parameter bit DROP_WHEN_FULL = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  AXIS_IF.Slave                 in_axis_if,
  AXIS_IF.Master                out_axis_if,
  output logic                  status_overflow,
  output logic                  status_bad_frame,
  output logic                  status_good_frame,
  output logic [$clog2(DEPTH):0] status_depth
);

  localparam int c_addr_w = $clog2(DEPTH);
  localparam int c_ptr_w  = c_addr_w + 1;
  localparam int c_data_w = in_axis_if.TDATA_WIDTH;
  localparam int c_keep_w = (c_data_w + 7) / 8;
  localparam int c_id_w   = in_axis_if.TID_WIDTH;
  localparam int c_dest_w = in_axis_if.TDEST_WIDTH;
  localparam int c_user_w = in_axis_if.TUSER_WIDTH;
  localparam int c_word_w = c_data_w + c_keep_w + 1 + c_id_w + c_dest_w + c_user_w;

  localparam logic [c_ptr_w-1:0] c_ptr_one = c_ptr_w'(1);
  localparam logic [c_ptr_w-1:0] c_depth_p = c_ptr_w'(DEPTH);

  if (c_data_w <= 0) begin : g_chk_data_w
    $error("axis_frame_fifo: TDATA_WIDTH must be greater than zero");
  end
  if (in_axis_if.TDATA_WIDTH != out_axis_if.TDATA_WIDTH ||
      in_axis_if.TID_WIDTH   != out_axis_if.TID_WIDTH   ||
      in_axis_if.TDEST_WIDTH != out_axis_if.TDEST_WIDTH ||
      in_axis_if.TUSER_WIDTH != out_axis_if.TUSER_WIDTH) begin : g_chk_widths
    $error("axis_frame_fifo: input and output stream widths differ");
  end
  if (in_axis_if.TWAKEUP_ENABLE != 0 || out_axis_if.TWAKEUP_ENABLE != 0) begin : g_chk_wakeup
    $error("axis_frame_fifo: TWAKEUP is not supported");
  end
  if (!is_pow2(DEPTH) || DEPTH < c_min_depth) begin : g_chk_depth
    $error("axis_frame_fifo: DEPTH must be a power of two and at least 4");
  end

  write_state_e       r_state;
  write_state_e       w_state_next;
  logic [c_ptr_w-1:0] r_wr_ptr_cur;
  logic [c_ptr_w-1:0] r_wr_ptr_commit;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_ptr_w-1:0] w_wr_ptr_cur_next;
  logic [c_ptr_w-1:0] w_wr_ptr_commit_next;
  logic               r_out_valid;
  logic               r_status_overflow;
  logic               r_status_bad_frame;
  logic               r_status_good_frame;

  logic               w_full;
  logic               w_commit_empty;
  logic               w_in_ready;
  logic               w_wr_en;
  logic               w_commit;
  logic               w_bad;
  logic               w_rollback;
  logic               w_overflow;
  logic               w_rd_en;
  logic [c_word_w-1:0] w_wr_word;
  logic [c_word_w-1:0] w_rd_word;
  logic               w_unused;

  assign w_full         = (r_wr_ptr_cur - r_rd_ptr) == c_depth_p;
  assign w_commit_empty = (r_wr_ptr_commit == r_rd_ptr);

  // Write-side decisions for the current beat.
  always_comb begin
    w_in_ready = 1'b0;
    w_wr_en    = 1'b0;
    w_commit   = 1'b0;
    w_bad      = 1'b0;
    w_rollback = 1'b0;
    w_overflow = 1'b0;
    if (!reset) begin
      case (r_state)
        NORMAL: begin
          w_in_ready = !w_full || DROP_WHEN_FULL || w_commit_empty;
          if (in_axis_if.tvalid && w_in_ready) begin
            if (!w_full) begin
              w_wr_en = 1'b1;
              if (in_axis_if.tlast) begin
                if (DROP_BAD_FRAME && in_axis_if.tuser[0]) begin
                  w_bad = 1'b1;
                end else begin
                  w_commit = 1'b1;
                end
              end
            end else begin
              w_rollback = 1'b1;
              w_overflow = in_axis_if.tlast;
            end
          end
        end
        DROP: begin
          w_in_ready = 1'b1;
          w_overflow = in_axis_if.tvalid && in_axis_if.tlast;
        end
        default: begin
          w_in_ready = 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    w_state_next         = r_state;
    w_wr_ptr_cur_next    = r_wr_ptr_cur;
    w_wr_ptr_commit_next = r_wr_ptr_commit;
    if (w_wr_en) begin
      w_wr_ptr_cur_next = r_wr_ptr_cur + c_ptr_one;
    end
    if (w_commit) begin
      w_wr_ptr_commit_next = r_wr_ptr_cur + c_ptr_one;
    end
    if (w_bad || w_rollback) begin
      w_wr_ptr_cur_next = r_wr_ptr_commit;
    end
    case (r_state)
      NORMAL:  if (w_rollback && !in_axis_if.tlast) w_state_next = DROP;
      DROP:    if (w_overflow) w_state_next = NORMAL;
      default: w_state_next = NORMAL;
    endcase
  end

  // Reads stop at the commit pointer, so a concurrent rollback never exposes partial data.
  assign w_rd_en = !w_commit_empty && (!r_out_valid || out_axis_if.tready);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state             <= NORMAL;
      r_wr_ptr_cur        <= '0;
      r_wr_ptr_commit     <= '0;
      r_rd_ptr            <= '0;
      r_out_valid         <= 1'b0;
      r_status_overflow   <= 1'b0;
      r_status_bad_frame  <= 1'b0;
      r_status_good_frame <= 1'b0;
    end else begin
      r_state             <= w_state_next;
      r_wr_ptr_cur        <= w_wr_ptr_cur_next;
      r_wr_ptr_commit     <= w_wr_ptr_commit_next;
      r_status_overflow   <= w_overflow;
      r_status_bad_frame  <= w_bad;
      r_status_good_frame <= w_commit;
      if (w_rd_en) begin
        r_rd_ptr    <= r_rd_ptr + c_ptr_one;
        r_out_valid <= 1'b1;
      end else if (out_axis_if.tready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign w_wr_word = {in_axis_if.tdata, in_axis_if.tkeep, in_axis_if.tlast,
                      in_axis_if.tid, in_axis_if.tdest, in_axis_if.tuser};

  axis_fifo_ram #(
    .WIDTH (c_word_w),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk       (clk),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (r_wr_ptr_cur[c_addr_w-1:0]),
    .i_wr_data (w_wr_word),
    .i_rd_en   (w_rd_en),
    .i_rd_addr (r_rd_ptr[c_addr_w-1:0]),
    .o_rd_data (w_rd_word)
  );

  assign in_axis_if.tready = w_in_ready;

  assign out_axis_if.tvalid  = r_out_valid;
  assign {out_axis_if.tdata, out_axis_if.tkeep, out_axis_if.tlast,
          out_axis_if.tid, out_axis_if.tdest, out_axis_if.tuser} = w_rd_word;
  assign out_axis_if.tstrb   = '0;
  assign out_axis_if.twakeup = 1'b0;

  assign status_overflow   = r_status_overflow;
  assign status_bad_frame  = r_status_bad_frame;
  assign status_good_frame = r_status_good_frame;
  assign status_depth      = r_wr_ptr_cur - r_rd_ptr;

  assign w_unused = &{1'b0, in_axis_if.tstrb, in_axis_if.twakeup};

endmodule

`default_nettype wire

// File: tb/tb_axis_frame_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : tb_axis_frame_fifo
// Purpose  : Scoreboard bench for axis_frame_fifo with DEPTH=16.
// Revision : 1.0
// ---------------------------------------------------------------------------
module tb_axis_frame_fifo;

  localparam int c_depth = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       status_overflow;
  logic       status_bad_frame;
  logic       status_good_frame;
  logic [4:0] status_depth;

  AXIS_IF #(.TDATA_WIDTH(8)) in_if ();
  AXIS_IF #(.TDATA_WIDTH(8)) out_if ();

  axis_frame_fifo #(
    .DEPTH          (c_depth),
    .DROP_BAD_FRAME (1'b1),
    .DROP_WHEN_FULL (1'b0)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .in_axis_if        (in_if),
    .out_axis_if       (out_if),
    .status_overflow   (status_overflow),
    .status_bad_frame  (status_bad_frame),
    .status_good_frame (status_good_frame),
    .status_depth      (status_depth)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad = 0;
  int n_out = 0;
  int n_good = 0;
  int n_badf = 0;
  int n_ovf = 0;
  int stalls = 0;
  int ready_mode = 1;
  logic [9:0] sb [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Output ready changes just after the rising edge so the monitor sees it stable.
  initial begin
    out_if.tready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       out_if.tready = 1'b0;
        1:       out_if.tready = 1'b1;
        default: out_if.tready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  initial begin
    logic [9:0] beat;
    logic [9:0] exp_beat;
    logic [9:0] prev_beat;
    logic       prev_stall;
    prev_beat  = '0;
    prev_stall = 1'b0;
    forever begin
      @(negedge clk);
      beat = {out_if.tuser[0], out_if.tlast, out_if.tdata};
      if (reset) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          chk("hold", {21'b0, out_if.tvalid, beat}, {21'b0, 1'b1, prev_beat});
        end
        if (out_if.tvalid && out_if.tready) begin
          chk("extra_beat", 32'(sb.size() == 0), 32'd0);
          if (sb.size() != 0) begin
            exp_beat = sb.pop_front();
            chk("beat", 32'(beat), 32'(exp_beat));
          end
          n_out++;
        end
        prev_stall = out_if.tvalid && !out_if.tready;
        prev_beat  = beat;
        if (status_good_frame) n_good++;
        if (status_bad_frame)  n_badf++;
        if (status_overflow)   n_ovf++;
      end
    end
  end

  task automatic send_beat(input logic [7:0] data, input logic last, input logic user);
    int waited;
    in_if.tvalid = 1'b1;
    in_if.tdata  = data;
    in_if.tlast  = last;
    in_if.tuser  = user;
    waited = 0;
    while (!in_if.tready && waited < 2000) begin
      @(negedge clk);
      waited++;
      stalls++;
    end
    if (waited >= 2000) chk("in_ready_timeout", 32'(in_if.tready), 32'd1);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send_frame(input int len, input logic [7:0] base, input logic [7:0] step,
                            input bit bad, input bit rnd);
    logic [7:0] d [$];
    for (int i = 0; i < len; i++) begin
      if (rnd) d.push_back(8'($urandom));
      else     d.push_back(base + 8'(i) * step);
    end
    if (!bad && len <= c_depth) begin
      for (int i = 0; i < len; i++) sb.push_back({1'b0, i == len - 1, d[i]});
    end
    for (int i = 0; i < len; i++) send_beat(d[i], i == len - 1, bad && (i == len - 1));
    in_if.tvalid = 1'b0;
    in_if.tlast  = 1'b0;
    in_if.tuser  = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || out_if.tvalid) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    int g0, b0, o0, s0, out0;
    reset          = 1'b1;
    in_if.tvalid   = 1'b0;
    in_if.tdata    = '0;
    in_if.tkeep    = '1;
    in_if.tstrb    = '0;
    in_if.tlast    = 1'b0;
    in_if.tid      = '0;
    in_if.tdest    = '0;
    in_if.tuser    = '0;
    in_if.twakeup  = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(in_if.tready), 32'd0);
    chk("rst_valid", 32'(out_if.tvalid), 32'd0);
    chk("rst_depth", 32'(status_depth), 32'd0);
    chk("rst_pulses", {29'b0, status_overflow, status_bad_frame, status_good_frame}, 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("idle_in_ready", 32'(in_if.tready), 32'd1);

    // Single good frame: latency, tlast placement, commit pulse.
    send_frame(4, 8'h11, 8'h11, 1'b0, 1'b0);
    chk("t1_good_pulse", 32'(status_good_frame), 32'd1);
    chk("t1_lat_c1", 32'(out_if.tvalid), 32'd0);
    @(negedge clk);
    chk("t1_lat_c2", 32'(out_if.tvalid), 32'd1);
    chk("t1_first", 32'(out_if.tdata), 32'h11);
    wait_drain();
    chk("t1_good_cnt", 32'(n_good), 32'd1);
    chk("t1_depth", 32'(status_depth), 32'd0);

    // Bad frame discarded, following good frame passes.
    g0 = n_good; b0 = n_badf;
    send_frame(3, 8'hA0, 8'h01, 1'b1, 1'b0);
    chk("t2_bad_pulse", 32'(status_bad_frame), 32'd1);
    chk("t2_depth_bad", 32'(status_depth), 32'd0);
    send_frame(2, 8'hB0, 8'h01, 1'b0, 1'b0);
    wait_drain();
    chk("t2_bad_cnt", 32'(n_badf - b0), 32'd1);
    chk("t2_good_cnt", 32'(n_good - g0), 32'd1);

    // Oversize frame dropped without back-pressure.
    o0 = n_ovf; s0 = stalls; out0 = n_out;
    send_frame(20, 8'h01, 8'h01, 1'b0, 1'b0);
    chk("t3_ovf_pulse", 32'(status_overflow), 32'd1);
    chk("t3_stalls", 32'(stalls - s0), 32'd0);
    repeat (4) @(negedge clk);
    chk("t3_no_out", 32'(n_out - out0), 32'd0);
    send_frame(2, 8'hC0, 8'h01, 1'b0, 1'b0);
    wait_drain();
    chk("t3_ovf_cnt", 32'(n_ovf - o0), 32'd1);
    chk("t3_out_cnt", 32'(n_out - out0), 32'd2);

    // Fill with output stalled, then release.
    ready_mode = 0;
    repeat (2) @(negedge clk);
    out0 = n_out;
    for (int f = 0; f < 4; f++) send_frame(4, 8'(8'h40 + 16 * f), 8'h01, 1'b0, 1'b0);
    fork
      send_frame(4, 8'h80, 8'h01, 1'b0, 1'b0);
      begin
        int n;
        n = 0;
        while (in_if.tready && n < 50) begin
          @(negedge clk);
          n++;
        end
        chk("t4_in_ready_low", 32'(in_if.tready), 32'd0);
        repeat (5) @(negedge clk);
        ready_mode = 1;
      end
    join
    wait_drain();
    chk("t4_out_cnt", 32'(n_out - out0), 32'd20);

    // Random frames with random output back-pressure.
    ready_mode = 2;
    for (int f = 0; f < 100; f++) begin
      send_frame($urandom_range(1, 12), 8'h00, 8'h00, $urandom_range(0, 3) == 0, 1'b1);
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end
    ready_mode = 1;
    wait_drain();
    chk("t5_depth", 32'(status_depth), 32'd0);

    // Reset with two stored frames and a partial one.
    ready_mode = 0;
    repeat (2) @(negedge clk);
    send_frame(3, 8'h60, 8'h01, 1'b0, 1'b0);
    send_frame(2, 8'h70, 8'h01, 1'b0, 1'b0);
    send_beat(8'h90, 1'b0, 1'b0);
    send_beat(8'h91, 1'b0, 1'b0);
    in_if.tvalid = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    sb.delete();
    @(negedge clk);
    chk("t6_rst_in_ready", 32'(in_if.tready), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("t6_valid", 32'(out_if.tvalid), 32'd0);
    chk("t6_depth", 32'(status_depth), 32'd0);
    ready_mode = 1;
    out0 = n_out;
    send_frame(3, 8'hD0, 8'h01, 1'b0, 1'b0);
    wait_drain();
    repeat (4) @(negedge clk);
    chk("t6_out_cnt", 32'(n_out - out0), 32'd3);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
